// File: rtl/lc3_pkg.sv
// Shared types and encodings for the LC-3 control state machine:
// state constants, the packed control word and the mux/ALU select codes.
package lc3_pkg;

  typedef logic [4:0] state_t;

  localparam state_t S_HALT   = 5'd0;
  localparam state_t S_F1     = 5'd1;
  localparam state_t S_F2     = 5'd2;
  localparam state_t S_F3     = 5'd3;
  localparam state_t S_DEC    = 5'd4;
  localparam state_t S_ADD    = 5'd5;
  localparam state_t S_AND    = 5'd6;
  localparam state_t S_NOT    = 5'd7;
  localparam state_t S_BR     = 5'd8;
  localparam state_t S_BR_T   = 5'd9;
  localparam state_t S_JMP    = 5'd10;
  localparam state_t S_JSR1   = 5'd11;
  localparam state_t S_JSR2   = 5'd12;
  localparam state_t S_LDR1   = 5'd13;
  localparam state_t S_LDR2   = 5'd14;
  localparam state_t S_LDR3   = 5'd15;
  localparam state_t S_STR1   = 5'd16;
  localparam state_t S_STR2   = 5'd17;
  localparam state_t S_STR3   = 5'd18;
  localparam state_t S_PAUSE1 = 5'd19;
  localparam state_t S_PAUSE2 = 5'd20;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic       ADDR1_PC    = 1'b0;
  localparam logic       ADDR1_BASER = 1'b1;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  typedef struct packed {
    logic       LD_MAR;
    logic       LD_MDR;
    logic       LD_IR;
    logic       LD_BEN;
    logic       LD_CC;
    logic       LD_REG;
    logic       LD_PC;
    logic       LD_LED;
    logic       GatePC;
    logic       GateMDR;
    logic       GateALU;
    logic       GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX;
    logic       SR1MUX;
    logic       SR2MUX;
    logic       ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/lc3_control_fsm.sv
// Moore control FSM for the simplified LC-3 datapath: fetch, decode and
// execute sequencing with a wait counter that stretches memory states.
module lc3_control_fsm
  import lc3_pkg::*;
#(
  parameter int MEM_DELAY = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output ctrl_t      Ctrl,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  localparam int               CNT_W    = $clog2(MEM_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_DELAY - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_state, mem_done;

  assign mem_state = (state == S_F2) || (state == S_LDR2) || (state == S_STR3);
  assign mem_done  = (wait_cnt == CNT_LAST);

  // Counter returns to zero whenever a memory state is left, so every entry starts fresh.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_HALT;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (mem_state && !mem_done) ? wait_cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HALT:   if (Run) state_nxt = S_F1;
      S_F1:     state_nxt = S_F2;
      S_F2:     if (mem_done) state_nxt = S_F3;
      S_F3:     state_nxt = S_DEC;
      S_DEC: begin
        case (Opcode)
          OP_ADD:   state_nxt = S_ADD;
          OP_AND:   state_nxt = S_AND;
          OP_NOT:   state_nxt = S_NOT;
          OP_BR:    state_nxt = S_BR;
          OP_JMP:   state_nxt = S_JMP;
          OP_JSR:   state_nxt = S_JSR1;
          OP_LDR:   state_nxt = S_LDR1;
          OP_STR:   state_nxt = S_STR1;
          OP_PAUSE: state_nxt = S_PAUSE1;
          default:  state_nxt = S_F1;
        endcase
      end
      S_ADD, S_AND, S_NOT:          state_nxt = S_F1;
      S_BR:                         state_nxt = BEN ? S_BR_T : S_F1;
      S_BR_T, S_JMP, S_JSR2, S_LDR3: state_nxt = S_F1;
      S_JSR1:   state_nxt = S_JSR2;
      S_LDR1:   state_nxt = S_LDR2;
      S_LDR2:   if (mem_done) state_nxt = S_LDR3;
      S_STR1:   state_nxt = S_STR2;
      S_STR2:   state_nxt = S_STR3;
      S_STR3:   if (mem_done) state_nxt = S_F1;
      S_PAUSE1: if (Continue) state_nxt = S_PAUSE2;
      S_PAUSE2: if (!Continue) state_nxt = S_F1;
      default:  state_nxt = S_HALT;
    endcase
  end

  always_comb begin
    Ctrl   = CTRL_IDLE;
    Mem_OE = 1'b0;
    Mem_WE = 1'b0;
    case (state)
      S_F1: begin
        Ctrl.GatePC = 1'b1;
        Ctrl.LD_MAR = 1'b1;
        Ctrl.LD_PC  = 1'b1;
        Ctrl.PCMUX  = PCMUX_INC;
      end
      S_F2, S_LDR2: begin
        Mem_OE      = 1'b1;
        Ctrl.LD_MDR = mem_done;
      end
      S_F3: begin
        Ctrl.GateMDR = 1'b1;
        Ctrl.LD_IR   = 1'b1;
      end
      S_DEC: Ctrl.LD_BEN = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        Ctrl.GateALU = 1'b1;
        Ctrl.LD_REG  = 1'b1;
        Ctrl.LD_CC   = 1'b1;
        Ctrl.ALUK    = (state == S_ADD) ? ALUK_ADD : (state == S_AND) ? ALUK_AND : ALUK_NOT;
        Ctrl.SR2MUX  = (state != S_NOT) && IR_5;
      end
      S_BR_T: begin
        Ctrl.LD_PC    = 1'b1;
        Ctrl.PCMUX    = PCMUX_ADDER;
        Ctrl.ADDR1MUX = ADDR1_PC;
        Ctrl.ADDR2MUX = ADDR2_OFF9;
      end
      S_JMP: begin
        Ctrl.LD_PC    = 1'b1;
        Ctrl.PCMUX    = PCMUX_ADDER;
        Ctrl.ADDR1MUX = ADDR1_BASER;
        Ctrl.ADDR2MUX = ADDR2_ZERO;
      end
      S_JSR1: begin
        Ctrl.GatePC = 1'b1;
        Ctrl.DRMUX  = 1'b1;
        Ctrl.LD_REG = 1'b1;
      end
      S_JSR2: begin
        Ctrl.LD_PC    = 1'b1;
        Ctrl.PCMUX    = PCMUX_ADDER;
        Ctrl.ADDR1MUX = IR_11 ? ADDR1_PC : ADDR1_BASER;
        Ctrl.ADDR2MUX = IR_11 ? ADDR2_OFF11 : ADDR2_ZERO;
      end
      S_LDR1, S_STR1: begin
        Ctrl.GateMARMUX = 1'b1;
        Ctrl.LD_MAR     = 1'b1;
        Ctrl.ADDR1MUX   = ADDR1_BASER;
        Ctrl.ADDR2MUX   = ADDR2_OFF6;
      end
      S_LDR3: begin
        Ctrl.GateMDR = 1'b1;
        Ctrl.LD_REG  = 1'b1;
        Ctrl.LD_CC   = 1'b1;
      end
      S_STR2: begin
        Ctrl.GateALU = 1'b1;
        Ctrl.ALUK    = ALUK_PASSA;
        Ctrl.LD_MDR  = 1'b1;
      end
      S_STR3:   Mem_WE = 1'b1;
      S_PAUSE1: Ctrl.LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule
